// File: rtl/nn_layer_pkg.sv
// Shared definitions for the neural-network layer datapath: default sizes
// and the layer sequencer state encodings.
package nn_layer_pkg;

    localparam int DATA_W_DEFAULT      = 32;
    localparam int MAX_NEURONS_DEFAULT = 16;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_SUM_START = 3'd1;
    localparam logic [STATE_W-1:0] ST_SUM_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACT_START = 3'd3;
    localparam logic [STATE_W-1:0] ST_ACT_WAIT  = 3'd4;
    localparam logic [STATE_W-1:0] ST_OUT       = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd6;

endpackage

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks one layer pass neuron by neuron, launching the
// external summation unit and (optionally) the Elliot activation unit through
// the shared layer mux, then hands each result downstream with valid/ready.
// Every output is a flop loaded from the next-state decode, so outputs line
// up exactly with the state the FSM occupies.
module layer_sequencer
    import nn_layer_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int MAX_NEURONS = MAX_NEURONS_DEFAULT,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    layer_size,
    input  logic              bypass_act,
    input  logic              abort,
    output logic              sum_start,
    output logic              act_start,
    output logic              sel,
    input  logic [DATA_W-1:0] mux_y,
    input  logic              mux_done,
    output logic [IDX_W-1:0]  neuron_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              layer_done
);

    localparam logic [IDX_W:0] MAX_SIZE = (IDX_W + 1)'(MAX_NEURONS);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [IDX_W:0]     r_size;
    logic               r_bypass;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_sum_start;
    logic               r_act_start;
    logic               r_sel;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_layer_done;

    logic [IDX_W:0]     w_size_clamped;
    logic               w_last;
    logic               w_accept;
    logic               w_capture;

    assign w_size_clamped = (layer_size > MAX_SIZE) ? MAX_SIZE : layer_size;
    assign w_last         = ({1'b0, r_idx} == (r_size - 1'b1));
    assign w_accept       = (r_state == ST_IDLE) && start;
    // OUT is only entered from a wait state, so entering it means a result lands.
    assign w_capture      = (w_next == ST_OUT) && (r_state != ST_OUT);

    // Next-state decode; abort overrides every other transition outside IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_size_clamped == '0) ? ST_DONE : ST_SUM_START;
                end
            end
            ST_SUM_START: w_next = ST_SUM_WAIT;
            ST_SUM_WAIT: begin
                if (mux_done) begin
                    w_next = r_bypass ? ST_OUT : ST_ACT_START;
                end
            end
            ST_ACT_START: w_next = ST_ACT_WAIT;
            ST_ACT_WAIT: begin
                if (mux_done) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_next = w_last ? ST_DONE : ST_SUM_START;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    // State, latched pass configuration, neuron index and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_size     <= '0;
            r_bypass   <= 1'b0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size   <= w_size_clamped;
                r_bypass <= bypass_act;
                r_idx    <= '0;
            end
            if ((r_state == ST_OUT) && (w_next == ST_SUM_START)) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_capture) begin
                r_out_data <= mux_y;
            end
        end
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_start  <= 1'b0;
            r_act_start  <= 1'b0;
            r_sel        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_sum_start  <= (w_next == ST_SUM_START);
            r_act_start  <= (w_next == ST_ACT_START);
            r_sel        <= (w_next == ST_ACT_START) || (w_next == ST_ACT_WAIT);
            r_out_valid  <= (w_next == ST_OUT);
            r_busy       <= (w_next != ST_IDLE);
            r_layer_done <= (w_next == ST_DONE);
        end
    end

    assign sum_start  = r_sum_start;
    assign act_start  = r_act_start;
    assign sel        = r_sel;
    assign neuron_idx = r_idx;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign layer_done = r_layer_done;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed testbench for layer_sequencer with an optional automatic mux
// responder and a passive monitor counting launches and transfers.
module tb_layer_sequencer;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IDX_W:0]    layer_size;
    logic              bypass_act;
    logic              abort;
    logic              sum_start;
    logic              act_start;
    logic              sel;
    logic [DATA_W-1:0] mux_y;
    logic              mux_done;
    logic [IDX_W-1:0]  neuron_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              layer_done;

    logic              autoRespond;
    logic              manDone;
    logic [DATA_W-1:0] manY;
    logic              respDone;
    logic [DATA_W-1:0] respY;
    int                pendingCnt;
    logic [DATA_W-1:0] pendingVal;

    int sumCount  = 0;
    int actCount  = 0;
    int selCount  = 0;
    int doneCount = 0;
    int xferCount = 0;
    logic [IDX_W-1:0]  xferIdx  [64];
    logic [DATA_W-1:0] xferData [64];

    int testCount = 0;
    int failCount = 0;

    int baseSum, baseAct, baseSel, baseDone, baseXfer;
    int bad;
    int gap;
    bit seen;

    assign mux_done = autoRespond ? respDone : manDone;
    assign mux_y    = autoRespond ? respY    : manY;

    layer_sequencer #(
        .DATA_W      (DATA_W),
        .MAX_NEURONS (16),
        .IDX_W       (IDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .layer_size (layer_size),
        .bypass_act (bypass_act),
        .abort      (abort),
        .sum_start  (sum_start),
        .act_start  (act_start),
        .sel        (sel),
        .mux_y      (mux_y),
        .mux_done   (mux_done),
        .neuron_idx (neuron_idx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .layer_done (layer_done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the design never finishes a pass.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion, expected $finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Auto responder: raise mux_done two cycles after each launch pulse.
    initial begin
        respDone   = 1'b0;
        respY      = '0;
        pendingCnt = 0;
        pendingVal = '0;
        forever begin
            @(posedge clk);
            #2;
            respDone = 1'b0;
            if (!autoRespond) begin
                pendingCnt = 0;
            end else begin
                if (pendingCnt > 0) begin
                    pendingCnt--;
                    if (pendingCnt == 0) begin
                        respDone = 1'b1;
                        respY    = pendingVal;
                    end
                end
                if (sum_start || act_start) begin
                    pendingCnt = 2;
                    pendingVal = act_start ? (32'hA000_0000 | {28'd0, neuron_idx})
                                           : (32'h5000_0000 | {28'd0, neuron_idx});
                end
            end
        end
    end

    // Passive monitor: counts pulses, sel cycles and accepted transfers.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sum_start)  sumCount++;
            if (act_start)  actCount++;
            if (sel)        selCount++;
            if (layer_done) doneCount++;
            if (out_valid && out_ready && !abort) begin
                if (xferCount < 64) begin
                    xferIdx[xferCount]  = neuron_idx;
                    xferData[xferCount] = out_data;
                end
                xferCount++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [IDX_W:0] size, input logic bypass);
        start      = 1'b1;
        layer_size = size;
        bypass_act = bypass;
        tick();
        start      = 1'b0;
    endtask

    task automatic waitLayerDone(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (layer_done) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic snapshot();
        baseSum  = sumCount;
        baseAct  = actCount;
        baseSel  = selCount;
        baseDone = doneCount;
        baseXfer = xferCount;
    endtask

    // Manual neuron without bypass, entered and left in SUM_START.
    task automatic stepNeuron(input logic [31:0] y);
        tick();
        manDone = 1'b1;
        tick();
        manDone = 1'b0;
        tick();
        manDone = 1'b1;
        manY    = y;
        tick();
        manDone = 1'b0;
        tick();
    endtask

    // Directed sequence of scenarios.
    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        layer_size  = '0;
        bypass_act  = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b1;
        autoRespond = 1'b0;
        manDone     = 1'b0;
        manY        = '0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_pulses", {27'd0, sum_start, act_start, sel, out_valid, layer_done}, 0);
        checkOutput("rst_idx", {28'd0, neuron_idx}, 0);
        checkOutput("rst_data", out_data, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_release_idle", {31'd0, busy}, 0);

        // Three neurons with activation, mux_done two cycles after each launch.
        autoRespond = 1'b1;
        snapshot();
        applyStimulus(5'd3, 1'b0);
        checkOutput("050_first_launch", {30'd0, sum_start, busy}, 32'h3);
        waitLayerDone(60, seen);
        checkOutput("050_done_seen", {31'd0, seen}, 1);
        tick();
        checkOutput("050_busy_after", {31'd0, busy}, 0);
        checkOutput("050_xfers", xferCount - baseXfer, 3);
        checkOutput("050_idx0", {28'd0, xferIdx[baseXfer]}, 0);
        checkOutput("050_idx1", {28'd0, xferIdx[baseXfer+1]}, 1);
        checkOutput("050_idx2", {28'd0, xferIdx[baseXfer+2]}, 2);
        checkOutput("050_data0", xferData[baseXfer], 32'hA000_0000);
        checkOutput("050_data2", xferData[baseXfer+2], 32'hA000_0002);
        checkOutput("050_sel_cycles", selCount - baseSel, 9);
        checkOutput("050_act_pulses", actCount - baseAct, 3);
        checkOutput("050_sum_pulses", sumCount - baseSum, 3);
        checkOutput("050_done_once", doneCount - baseDone, 1);

        // Minimum latency: mux_done held high, sum_start every 5 cycles.
        autoRespond = 1'b0;
        manDone     = 1'b1;
        manY        = 32'h0000_0077;
        applyStimulus(5'd2, 1'b0);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            gap++;
            if (sum_start) break;
        end
        checkOutput("025_latency", gap, 5);
        waitLayerDone(20, seen);
        checkOutput("025_done_seen", {31'd0, seen}, 1);
        checkOutput("025_data", out_data, 32'h0000_0077);
        manDone = 1'b0;
        tick();

        // Single neuron with bypass: no activation launch, sel stays low.
        snapshot();
        applyStimulus(5'd1, 1'b1);
        checkOutput("051_launch", {30'd0, sum_start, sel}, 32'h2);
        tick();
        manDone = 1'b1;
        manY    = 32'h0000_1234;
        tick();
        manDone = 1'b0;
        checkOutput("051_valid", {31'd0, out_valid}, 1);
        checkOutput("051_data", out_data, 32'h0000_1234);
        tick();
        checkOutput("051_layer_done", {31'd0, layer_done}, 1);
        tick();
        checkOutput("051_no_act", actCount - baseAct, 0);
        checkOutput("051_no_sel", selCount - baseSel, 0);

        // Backpressure: result held for 10 cycles, stray start/mux_done ignored.
        applyStimulus(5'd2, 1'b1);
        tick();
        manDone   = 1'b1;
        manY      = 32'h0000_CAFE;
        out_ready = 1'b0;
        tick();
        manY       = 32'h0000_DEAD;
        start      = 1'b1;
        layer_size = 5'd1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1)        bad++;
            if (out_data !== 32'h0000_CAFE) bad++;
            if (neuron_idx !== 4'd0)        bad++;
            if (sum_start !== 1'b0)         bad++;
        end
        checkOutput("052_hold_stable", bad, 0);
        start     = 1'b0;
        manDone   = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("052_release", {26'd0, sum_start, out_valid, neuron_idx}, 32'h21);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("052_abort_idle", {31'd0, busy}, 0);

        // Abort in ACT_WAIT of neuron 1 beats a simultaneous mux_done.
        snapshot();
        applyStimulus(5'd4, 1'b0);
        stepNeuron(32'h0000_1111);
        checkOutput("053_idx1", {27'd0, sum_start, neuron_idx}, 32'h11);
        tick();
        manDone = 1'b1;
        tick();
        manDone = 1'b0;
        tick();
        checkOutput("053_act_wait_sel", {31'd0, sel}, 1);
        abort   = 1'b1;
        manDone = 1'b1;
        manY    = 32'h0000_2222;
        tick();
        abort   = 1'b0;
        manDone = 1'b0;
        checkOutput("053_idle", {28'd0, busy, sel, out_valid, layer_done}, 0);
        checkOutput("053_no_capture", out_data, 32'h0000_1111);
        tick();
        checkOutput("053_no_done", doneCount - baseDone, 0);
        applyStimulus(5'd1, 1'b1);
        checkOutput("053_restart", {26'd0, sum_start, busy, neuron_idx}, 32'h30);
        tick();
        manDone = 1'b1;
        manY    = 32'h0000_3333;
        tick();
        manDone = 1'b0;
        checkOutput("053_restart_data", out_data, 32'h0000_3333);
        tick();
        checkOutput("053_restart_done", {31'd0, layer_done}, 1);
        tick();

        // Empty layer goes straight to DONE.
        snapshot();
        applyStimulus(5'd0, 1'b0);
        checkOutput("054_zero_done", {29'd0, layer_done, busy, sum_start}, 32'h6);
        tick();
        checkOutput("054_zero_idle", {30'd0, layer_done, busy}, 0);
        checkOutput("054_zero_no_sum", sumCount - baseSum, 0);

        // Oversized layer is clamped to 16 neurons.
        autoRespond = 1'b1;
        snapshot();
        applyStimulus(5'd20, 1'b1);
        waitLayerDone(200, seen);
        checkOutput("054_clamp_done_seen", {31'd0, seen}, 1);
        tick();
        checkOutput("054_clamp_xfers", xferCount - baseXfer, 16);
        checkOutput("054_clamp_sums", sumCount - baseSum, 16);
        checkOutput("054_clamp_last_idx", {28'd0, xferIdx[baseXfer+15]}, 15);
        checkOutput("054_clamp_last_data", xferData[baseXfer+15], 32'h5000_000F);
        checkOutput("054_clamp_done_once", doneCount - baseDone, 1);

        // Asynchronous reset mid-pass, then spurious mux_done while idle.
        applyStimulus(5'd3, 1'b0);
        tick();
        checkOutput("055_in_sum_wait", {30'd0, busy, sum_start}, 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("055_rst_flags", {26'd0, busy, sum_start, act_start, sel, out_valid, layer_done}, 0);
        checkOutput("055_rst_idx", {28'd0, neuron_idx}, 0);
        checkOutput("055_rst_data", out_data, 0);
        autoRespond = 1'b0;
        manDone     = 1'b1;
        manY        = 32'h0000_BEEF;
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b0)      bad++;
            if (sum_start !== 1'b0) bad++;
            if (out_valid !== 1'b0) bad++;
            if (out_data !== '0)    bad++;
        end
        checkOutput("055_spurious_idle", bad, 0);
        manDone = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
